// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port arbiter with outstanding-read ID FIFO in front of an SDRAM Avalon slave
//
// Purpose:
//   Arbitrates port A (host/SPI frame writer) and port B (display fetch reader)
//   onto one SDRAM Avalon-MM slave (s1_*). The grant is round-robin, and a
//   grant is cut after MAX_BURST accepted transfers while the other port waits.
//   Reads are pipelined. Each accepted read pushes its port ID into a FIFO, and
//   each s1_readdatavalid beat pops the head ID to steer the beat to that port.
//
// Configuration macro:
//   SDRAM_ARB_FIXED_PRI_EN - port B wins from idle and is never cut by
//                            MAX_BURST. Port A is still cut when B waits.
//
// Ports:
//   clk_clk, reset_reset                single clock, synchronous active-high reset
//   a_* / b_*                           requester ports: address, byteenable, read,
//                                       write, writedata in; waitrequest, readdata,
//                                       readdatavalid out
//   s1_address/byteenable_n/chipselect  request to the SDRAM slave
//   s1_writedata/read_n/write_n
//   s1_readdata/readdatavalid/          response and stall from the SDRAM slave
//   s1_waitrequest
//   err_rdv_underflow                   sticky flag: a read beat arrived with no read pending
module sdram_port_arbiter #(
   parameter int ADDR_W      = 22,
   parameter int DATA_W      = 16,
   parameter int MAX_PENDING = 8,
   parameter int MAX_BURST   = 16
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [1:0]        a_byteenable,
   input  logic              a_read,
   input  logic              a_write,
   input  logic [DATA_W-1:0] a_writedata,
   output logic              a_waitrequest,
   output logic [DATA_W-1:0] a_readdata,
   output logic              a_readdatavalid,
   input  logic [ADDR_W-1:0] b_address,
   input  logic [1:0]        b_byteenable,
   input  logic              b_read,
   input  logic              b_write,
   input  logic [DATA_W-1:0] b_writedata,
   output logic              b_waitrequest,
   output logic [DATA_W-1:0] b_readdata,
   output logic              b_readdatavalid,
   output logic [ADDR_W-1:0] s1_address,
   output logic [1:0]        s1_byteenable_n,
   output logic              s1_chipselect,
   output logic [DATA_W-1:0] s1_writedata,
   output logic              s1_read_n,
   output logic              s1_write_n,
   input  logic [DATA_W-1:0] s1_readdata,
   input  logic              s1_readdatavalid,
   input  logic              s1_waitrequest,
   output logic              err_rdv_underflow
);

   localparam int PTR_W  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
   localparam int CNT_W  = $clog2(MAX_PENDING + 1);
   localparam int BEAT_W = $clog2(MAX_BURST + 1);

`ifdef SDRAM_ARB_FIXED_PRI_EN
   localparam bit CUT_B = 1'b0;
`else
   localparam bit CUT_B = 1'b1;
`endif

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_A    = 2'd1,
      GNT_B    = 2'd2
   } grant_t;

   grant_t              grant_q, grant_d;
   logic                rr_ptr_q, rr_ptr_d;     // 0 = A next, 1 = B next
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [MAX_PENDING-1:0] id_q;                // 1 = read belongs to port B
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q;
   logic                err_q;

   logic                a_req, b_req;
   logic                g_read, g_write, g_rd, g_req;
   logic [ADDR_W-1:0]   g_addr;
   logic [1:0]          g_be;
   logic [DATA_W-1:0]   g_wdata;
   logic                fifo_empty, fifo_full, pop, push, blocked, issue, accept;
   logic                head_id, burst_done;

   assign a_req = a_read | a_write;
   assign b_req = b_read | b_write;

   // Mux the granted port onto the slave side
   always_comb begin
      g_read  = 1'b0;
      g_write = 1'b0;
      g_addr  = '0;
      g_be    = '0;
      g_wdata = '0;
      unique case (grant_q)
         GNT_A: begin
            g_read  = a_read;
            g_write = a_write;
            g_addr  = a_address;
            g_be    = a_byteenable;
            g_wdata = a_writedata;
         end
         GNT_B: begin
            g_read  = b_read;
            g_write = b_write;
            g_addr  = b_address;
            g_be    = b_byteenable;
            g_wdata = b_writedata;
         end
         default: ;
      endcase
   end

   // Write wins when a port raises read and write together
   assign g_rd       = g_read & ~g_write;
   assign g_req      = g_read | g_write;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(MAX_PENDING));
   assign pop        = s1_readdatavalid & ~fifo_empty;
   // A pop in the same cycle frees a slot, so a full FIFO only blocks without one
   assign blocked    = g_rd & fifo_full & ~pop;
   assign issue      = g_req & ~blocked & ~reset_reset;
   assign accept     = issue & ~s1_waitrequest;
   assign push       = accept & g_rd;
   assign head_id    = id_q[rd_ptr_q];

   assign s1_chipselect   = issue;
   assign s1_read_n       = ~(issue & g_rd);
   assign s1_write_n      = ~(issue & g_write);
   assign s1_address      = g_addr;
   assign s1_byteenable_n = ~g_be;
   assign s1_writedata    = g_wdata;

   assign a_waitrequest   = reset_reset | (grant_q != GNT_A) | s1_waitrequest | blocked;
   assign b_waitrequest   = reset_reset | (grant_q != GNT_B) | s1_waitrequest | blocked;
   assign a_readdata      = s1_readdata;
   assign b_readdata      = s1_readdata;
   assign a_readdatavalid = pop & ~head_id & ~reset_reset;
   assign b_readdatavalid = pop &  head_id & ~reset_reset;
   assign err_rdv_underflow = err_q;

   // This accept is the MAX_BURST-th (or later) of the current grant
   assign burst_done = accept & (beat_cnt_q >= BEAT_W'(MAX_BURST - 1));

   always_comb begin
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      if (accept && (beat_cnt_q != BEAT_W'(MAX_BURST)))
         beat_cnt_d = beat_cnt_q + BEAT_W'(1);

      unique case (grant_q)
         GNT_NONE: begin
`ifdef SDRAM_ARB_FIXED_PRI_EN
            if (b_req)      grant_d = GNT_B;
            else if (a_req) grant_d = GNT_A;
`else
            if (a_req && b_req) grant_d = rr_ptr_q ? GNT_B : GNT_A;
            else if (a_req)     grant_d = GNT_A;
            else if (b_req)     grant_d = GNT_B;
`endif
         end
         GNT_A: begin
            if (!a_req)                  grant_d = b_req ? GNT_B : GNT_NONE;
            else if (burst_done && b_req) grant_d = GNT_B;
         end
         GNT_B: begin
            if (!b_req)                           grant_d = a_req ? GNT_A : GNT_NONE;
            else if (CUT_B && burst_done && a_req) grant_d = GNT_A;
         end
         default: grant_d = GNT_NONE;
      endcase

      if (grant_d != grant_q) begin
         beat_cnt_d = '0;
         if (grant_d == GNT_A)      rr_ptr_d = 1'b1;
         else if (grant_d == GNT_B) rr_ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         grant_q    <= GNT_NONE;
         rr_ptr_q   <= 1'b0;
         beat_cnt_q <= '0;
         id_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         if (push) begin
            id_q[wr_ptr_q] <= (grant_q == GNT_B);
            wr_ptr_q       <= wr_ptr_q + PTR_W'(1);
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: ;
         endcase
         if (s1_readdatavalid && fifo_empty)
            err_q <= 1'b1;
      end
   end

endmodule
